// File: rtl/voice_frame_collector_pkg.sv
`default_nettype none
// ============================================================================
// Module   : voice_frame_collector_pkg
// Brief    : Shared frame geometry for the voice/FFT path.
// Revision : 1.0
// ============================================================================
package voice_frame_collector_pkg;

    localparam int c_WIDTH     = 16;
    localparam int c_FRAME_LEN = 256;
    localparam int c_IDX_W     = $clog2(c_FRAME_LEN);

endpackage : voice_frame_collector_pkg
`default_nettype wire

// File: rtl/voice_frame_collector_frame_bank_ram.sv
`default_nettype none
// ============================================================================
// Module   : frame_bank_ram
// Brief    : One frame bank, single write port, combinational read port.
// Revision : 1.0
// ============================================================================
module frame_bank_ram
    import voice_frame_collector_pkg::*;
#(
    parameter int WIDTH  = c_WIDTH,
    parameter int DEPTH  = c_FRAME_LEN,
    parameter int ADDR_W = c_IDX_W
) (
    input  logic              clk,
    input  logic              i_we,
    input  logic [ADDR_W-1:0] i_wr_addr,
    input  logic [WIDTH-1:0]  i_wr_data,
    input  logic [ADDR_W-1:0] i_rd_addr,
    output logic [WIDTH-1:0]  o_rd_data
);

    logic [WIDTH-1:0] r_mem [DEPTH];

    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[i_wr_addr] <= i_wr_data;
        end
    end

    // Read sees pre-edge contents, so the replay register captures the old frame.
    assign o_rd_data = r_mem[i_rd_addr];

endmodule : frame_bank_ram
`default_nettype wire

// File: rtl/voice_frame_collector.sv
`default_nettype none
// ============================================================================
// Module   : voice_frame_collector
// Brief    : Ping-pong frame buffer; output is the input delayed one frame.
// Revision : 1.0
// ============================================================================
module voice_frame_collector
    import voice_frame_collector_pkg::*;
#(
    parameter int WIDTH     = c_WIDTH,
    parameter int FRAME_LEN = c_FRAME_LEN,
    parameter int IDX_W     = c_IDX_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] i_sram_data,
    output logic [WIDTH-1:0] o_sram_data_256
);

    logic [IDX_W-1:0] r_wr_idx;
    logic             r_wr_bank;
    logic             r_frame_valid;
    logic [WIDTH-1:0] r_sram_data_256;

    logic [1:0]       w_we;
    logic [WIDTH-1:0] w_bank_rd [2];
    logic [WIDTH-1:0] w_rd_data;
    logic             w_last;

    generate
        for (genvar b = 0; b < 2; b++) begin : g_bank
            assign w_we[b] = (r_wr_bank == 1'(b));

            frame_bank_ram #(
                .WIDTH  (WIDTH),
                .DEPTH  (FRAME_LEN),
                .ADDR_W (IDX_W)
            ) u_bank (
                .clk       (clk),
                .i_we      (w_we[b]),
                .i_wr_addr (r_wr_idx),
                .i_wr_data (i_sram_data),
                .i_rd_addr (r_wr_idx),
                .o_rd_data (w_bank_rd[b])
            );
        end
    endgenerate

    // Replay always comes from the bank not being written.
    assign w_rd_data = r_wr_bank ? w_bank_rd[0] : w_bank_rd[1];
    assign w_last    = (r_wr_idx == IDX_W'(FRAME_LEN - 1));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_wr_idx        <= '0;
            r_wr_bank       <= 1'b0;
            r_frame_valid   <= 1'b0;
            r_sram_data_256 <= '0;
        end else begin
            r_sram_data_256 <= r_frame_valid ? w_rd_data : '0;
            r_wr_idx        <= r_wr_idx + 1'b1;
            if (w_last) begin
                r_wr_bank     <= ~r_wr_bank;
                r_frame_valid <= 1'b1;
            end
        end
    end

    assign o_sram_data_256 = r_sram_data_256;

endmodule : voice_frame_collector
`default_nettype wire

// File: tb/tb_voice_frame_collector.sv
`default_nettype none
// ============================================================================
// Module   : tb_voice_frame_collector
// Brief    : Directed self-checking bench for the one-frame delay buffer.
// Revision : 1.0
// ============================================================================
module tb_voice_frame_collector;

    localparam int c_FL = 256;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [15:0] i_sram_data = '0;
    logic [15:0] o_sram_data_256;

    int n_checks = 0;
    int n_fail   = 0;

    logic [15:0] r_hist [$];
    string       phase = "reset_hold";

    voice_frame_collector dut (
        .clk             (clk),
        .rst             (rst),
        .i_sram_data     (i_sram_data),
        .o_sram_data_256 (o_sram_data_256)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Drive one sample, clock it in, then compare against the recorded history.
    task automatic step(input logic [15:0] d);
        int n;
        logic [15:0] exp;
        i_sram_data = d;
        @(posedge clk);
        #1;
        if (rst) begin
            r_hist.push_back(d);
            n   = r_hist.size() - 1;
            exp = (n >= c_FL) ? r_hist[n - c_FL] : 16'h0000;
        end else begin
            exp = 16'h0000;
        end
        check(phase, o_sram_data_256, exp);
    endtask

    // Asynchronous low pulse placed between edges, held across two edges.
    task automatic reset_pulse();
        #2;
        rst = 1'b0;
        #1;
        check("async_clear", o_sram_data_256, 16'h0000);
        r_hist.delete();
        repeat (2) begin
            @(posedge clk);
            #1;
            check("in_reset", o_sram_data_256, 16'h0000);
        end
        #3;
        rst = 1'b1;
    endtask

    logic [15:0] first_in  [4] = '{16'd10, 16'd9, 16'd8, 16'd9};
    logic [15:0] first_out [6] = '{16'd0, 16'd10, 16'd9, 16'd8, 16'd9, 16'd4};
    logic [15:0] wrap_in   [3] = '{16'hFFFE, 16'hFFFF, 16'h0000};

    initial begin
        logic [15:0] cnt;

        rst = 1'b0;
        #3;
        check("reset_value", o_sram_data_256, 16'h0000);
        repeat (8) step(16'($urandom));

        // Release between edges so the next edge is sample 0.
        @(negedge clk);
        rst = 1'b1;
        phase = "first_frame";
        for (int i = 0; i < 4; i++) step(first_in[i]);
        cnt = 16'd4;
        for (int i = 4; i < 261; i++) begin
            step(cnt);
            cnt = cnt + 16'd1;
            if (i >= 255) check("first_latency", o_sram_data_256, first_out[i - 255]);
        end

        phase = "stream";
        for (int i = 261; i < 1754; i++) begin
            step(cnt);
            cnt = cnt + 16'd1;
        end

        phase = "wrap_data";
        for (int i = 0; i < 3; i++) step(wrap_in[i]);
        for (int i = 0; i < 253; i++) begin
            step(cnt);
            cnt = cnt + 16'd1;
        end
        for (int i = 0; i < 3; i++) begin
            step(cnt);
            cnt = cnt + 16'd1;
            check("wrap_exact", o_sram_data_256, wrap_in[i]);
        end

        reset_pulse();
        phase = "pre_midreset";
        cnt = 16'h0100;
        for (int i = 0; i < 400; i++) begin
            step(cnt);
            cnt = cnt + 16'd1;
        end

        reset_pulse();
        phase = "constant";
        for (int i = 0; i < 600; i++) begin
            step(16'h1234);
            if (i == 255) check("const_last_zero", o_sram_data_256, 16'h0000);
            if (i == 256) check("const_first", o_sram_data_256, 16'h1234);
            if (i == 599) check("const_tail", o_sram_data_256, 16'h1234);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule : tb_voice_frame_collector
`default_nettype wire

// File: doc/voice_frame_collector.md
Name: voice_frame_collector

Overview:
- Front-end frame buffer for the voice/FFT path.
- Captures one 16-bit audio sample from SRAM readback every clock and groups samples into 256-sample frames.
- Replays the most recently completed frame, sample-by-sample, on a registered output while the next frame fills (ping-pong).
- Output is the input delayed by exactly one frame; it feeds the downstream FFT sink-side control.

Parameters:
- WIDTH, 16, sample width in bits (input and output).
- FRAME_LEN, 256, samples per frame; must be a power of two.
- IDX_W, 8, index width = log2(FRAME_LEN).

Ports:
- clk  input  1  system clock; one sample per rising edge.
- rst  input  1  asynchronous, active-low reset (0 = reset).
- i_sram_data  input  WIDTH  audio sample, sampled on every rising clk edge.
- o_sram_data_256  output  WIDTH  registered replay of the previous complete frame; 0 until the first frame completes.

Behaviour:
- Storage: two banks, each FRAME_LEN x WIDTH; registers or inferred RAM, read combinationally or one-cycle-registered internally so that output timing below holds.
- State:
  - wr_idx (IDX_W bits)
  - wr_bank (1 bit)
  - frame_valid (1 bit)
  - output register
- Reset (rst=0, asynchronous):
  - wr_idx=0, wr_bank=0, frame_valid=0, o_sram_data_256=0.
  - Bank contents need not be cleared.
- Every rising edge with rst=1:
  - bank[wr_bank][wr_idx] <= i_sram_data.
  - o_sram_data_256 <= frame_valid ? bank[~wr_bank][wr_idx] : 0 (the read uses the pre-edge contents).
  - wr_idx <= wr_idx+1, wrapping FRAME_LEN-1 -> 0.
  - When wr_idx == FRAME_LEN-1: wr_bank toggles and frame_valid <= 1 (sticky until reset).
- Latency:
  - The sample captured at edge n (n=0 is the first edge after reset release) is present on o_sram_data_256 immediately after edge n+FRAME_LEN.
  - This is exactly FRAME_LEN cycles, steady state, with no gaps at frame boundaries.
- First frame: output holds 0 through edge FRAME_LEN-1 inclusive; the first nonzero-capable value appears after edge FRAME_LEN.
- Wrap-around: the bank swap and the index wrap occur on the same edge. The last sample of frame k and the first output of frame k read different banks, so there is no read/write collision.
- Reset mid-frame:
  - All counters and the output clear immediately.
  - The partially collected frame is discarded.
  - The output returns to 0 for a full FRAME_LEN cycles after reset release.
- No handshake: the input is assumed valid every cycle and the output is valid every cycle after frame_valid.
- Arithmetic: no scaling; samples are passed bit-exact as unsigned WIDTH-bit words.

Decomposition:
- Shared package holds WIDTH, FRAME_LEN and IDX_W as constants, so FFT-path blocks agree on the frame size.
- One natural sub-module: frame_bank_ram, a single-bank FRAME_LEN x WIDTH memory with one write port and one read port. Instantiate it twice, with write enable steered by wr_bank.
- Counter and bank-select logic stay in the top.

Test Plan:
- Reset hold: assert rst=0 for 8 cycles with random i_sram_data -> o_sram_data_256 stays 0 and no X appears.
- First-frame latency:
  - Stimulus: release reset, drive 10, 9, 8, 9, then a free-running counter starting at 4 and incrementing each cycle.
  - Required: output is 0 for the first 256 edges; then 10, 9, 8, 9, 4, 5, 6, ...
- Continuous stream across frames:
  - Stimulus: drive the counter for 1750 cycles.
  - Required: output(t) = input(t-256) for every t >= 256, including each frame boundary (indices 255 -> 0) with no duplicated or dropped sample.
- Wrap of 16-bit data: drive values 0xFFFE, 0xFFFF, 0x0000 -> reproduced bit-exact 256 cycles later.
- Mid-frame reset:
  - Stimulus: after 400 samples, pulse rst=0 asynchronously between edges for 2 cycles, then resume.
  - Required: output drops to 0 immediately, stays 0 for 256 edges after release, then replays post-reset samples only.
- Constant input: drive 0x1234 for 600 cycles -> output is 0 for 256 cycles, then 0x1234 continuously.
